rf_wb_arbiter: RTL

Write-port arbiter and scoreboard for the 4 x 8-bit register file. Two producers, the ALU writeback and the input/load path, share the register file's single write port through round-robin arbitration and a registered write stage. A per-register pending scoreboard lets the decode stage reserve a destination at issue and stall operand reads until the reserved write lands.

---
 rtl/rf_wb_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-producer write-port arbiter and pending scoreboard for
// the 4 x 8-bit register file.
//
// The ALU writeback and the input/load path share one registered write port
// through round-robin arbitration. The decode stage reserves destinations at
// issue, and operand reads stall on `hazard` until the reserved write lands.
//
// Optional feature: define RF_ARB_BYPASS_EN so that `hazard` ignores the
// register being written in the current rf_we cycle. This releases the stall
// one cycle earlier, and decode must then sample operands after the falling
// edge of that cycle.
module rf_wb_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = 2
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [AW-1:0]       alu_wb,
    input  logic [DATA_W-1:0]   alu_data,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AW-1:0]       in_wb,
    input  logic [DATA_W-1:0]   in_data,

    input  logic                rsv_valid,
    output logic                rsv_ready,
    input  logic [AW-1:0]       rsv_wb,

    input  logic [AW-1:0]       ra,
    input  logic [AW-1:0]       rb,
    output logic                hazard,

    output logic                rf_we,
    output logic [AW-1:0]       rf_wb,
    output logic [DATA_W-1:0]   rf_data,
    output logic [(2**AW)-1:0]  pending
);

    localparam int unsigned NREG = 2**AW;

    // Requester encoding for the round-robin pointer.
    localparam logic PTR_ALU = 1'b0;
    localparam logic PTR_IN  = 1'b1;

    // Payload carried by the write stage.
    typedef struct packed {
        logic [AW-1:0]     wb;
        logic [DATA_W-1:0] data;
    } wr_payload_t;

    // State registers.
    logic              ptr_q;
    logic              ptr_d;
    logic              rf_we_q;
    logic              rf_we_d;
    wr_payload_t       wr_q;
    wr_payload_t       wr_d;
    logic [NREG-1:0]   pending_q;
    logic [NREG-1:0]   pending_d;

    // Combinational handshake terms.
    logic              alu_gnt_c;
    logic              in_gnt_c;
    logic              alu_xfer_c;
    logic              in_xfer_c;
    logic              rsv_ready_c;
    logic              rsv_xfer_c;
    logic [NREG-1:0]   pend_view_c;

    // Grant: a lone requester wins; on contention the pointer decides.
    always_comb begin
        alu_gnt_c = 1'b0;
        in_gnt_c  = 1'b0;
        if (alu_valid && in_valid) begin
            alu_gnt_c = (ptr_q == PTR_ALU);
            in_gnt_c  = (ptr_q == PTR_IN);
        end else begin
            alu_gnt_c = alu_valid;
            in_gnt_c  = in_valid;
        end
    end

    // A transfer is valid && ready at the rising edge.
    always_comb begin
        alu_xfer_c = alu_valid && alu_gnt_c;
        in_xfer_c  = in_valid && in_gnt_c;
    end

    // Pointer moves to the requester that did not win; idle cycles hold it.
    always_comb begin
        ptr_d = ptr_q;
        if (alu_xfer_c) begin
            ptr_d = PTR_IN;
        end else if (in_xfer_c) begin
            ptr_d = PTR_ALU;
        end
    end

    // Write stage: load the winner's payload, otherwise hold it with rf_we low.
    always_comb begin
        rf_we_d = 1'b0;
        wr_d    = wr_q;
        if (alu_xfer_c) begin
            rf_we_d    = 1'b1;
            wr_d.wb    = alu_wb;
            wr_d.data  = alu_data;
        end else if (in_xfer_c) begin
            rf_we_d    = 1'b1;
            wr_d.wb    = in_wb;
            wr_d.data  = in_data;
        end
    end

    // A reservation is only accepted on a register that is not already pending.
    always_comb begin
        rsv_ready_c = !pending_q[rsv_wb];
        rsv_xfer_c  = rsv_valid && rsv_ready_c;
    end

    // Scoreboard update: the landing write clears first, a new reservation
    // then sets, so a set on the same register wins (the write was the older one).
    always_comb begin
        pending_d = pending_q;
        if (rf_we_q) begin
            pending_d[wr_q.wb] = 1'b0;
        end
        if (rsv_xfer_c) begin
            pending_d[rsv_wb] = 1'b1;
        end
    end

    // Scoreboard as seen by the hazard check.
    always_comb begin
        pend_view_c = pending_q;
`ifdef RF_ARB_BYPASS_EN
        if (rf_we_q) begin
            pend_view_c[wr_q.wb] = 1'b0;
        end
`endif
    end

    // All state clears asynchronously so an in-flight write is dropped at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= PTR_ALU;
            rf_we_q   <= 1'b0;
            wr_q      <= '0;
            pending_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rf_we_q   <= rf_we_d;
            wr_q      <= wr_d;
            pending_q <= pending_d;
        end
    end

    // Output mapping.
    assign alu_ready = alu_gnt_c;
    assign in_ready  = in_gnt_c;
    assign rsv_ready = rsv_ready_c;
    assign hazard    = pend_view_c[ra] | pend_view_c[rb];
    assign rf_we     = rf_we_q;
    assign rf_wb     = wr_q.wb;
    assign rf_data   = wr_q.data;
    assign pending   = pending_q;

endmodule
